// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment driver: FSM encodings, segment codes,
// anode patterns and the BCD width used by ssd_mux_driver and bin_to_bcd_seq.
package ssd_pkg;

    localparam int BCD_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Cathodes are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_CODES [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [3:0] ANODE_PATTERNS [0:3] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) return SEG_CODES[digit];
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result published
// only after the full 13 shifts so bcd never shows a partial value.
module bin_to_bcd_seq
    import ssd_pkg::*;
#(
    parameter int NUM_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_W-1:0]   num,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd
);

    localparam int SR_W = BCD_W + NUM_W;

    if (NUM_W != 13) begin : g_bad_num_w
        $error("bin_to_bcd_seq: NUM_W must be 13");
    end

    logic [1:0]        state_q, state_d;
    logic [NUM_W-1:0]  last_q, last_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [SR_W-1:0] shift_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int i = 0; i < BCD_W / 4; i++) begin
            adj[NUM_W + 4*i +: 4] = dabble(sr[NUM_W + 4*i +: 4]);
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (num != last_q) begin
                    last_d  = num;
                    sr_d    = {{BCD_W{1'b0}}, num};
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = shift_step(sr_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd12) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = sr_q[SR_W-1:NUM_W];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift register is pure datapath and is reloaded before every use
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            cnt_q   <= 4'd0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_mux_driver.sv
// 4-digit common-anode display driver for the CPU ssd debug value.
// Define SSD_LZ_BLANK_EN to blank leading zeros (units digit always shown).
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int NUM_W        = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_W-1:0]   num,
    output logic [3:0]         anode,
    output logic [6:0]         seg,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd
);

    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    lz_blank;

    bin_to_bcd_seq #(.NUM_W(NUM_W)) u_conv (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .busy (busy),
        .bcd  (bcd)
    );

    assign refresh_d = refresh_q + REFRESH_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) refresh_q <= '0;
        else     refresh_q <= refresh_d;
    end

    assign sel   = refresh_q[REFRESH_BITS-1:REFRESH_BITS-2];
    assign anode = ANODE_PATTERNS[sel];

    always_comb begin
        digit = bcd[3:0];
        case (sel)
            2'd0: digit = bcd[3:0];
            2'd1: digit = bcd[7:4];
            2'd2: digit = bcd[11:8];
            2'd3: digit = bcd[15:12];
            default: digit = bcd[3:0];
        endcase
    end

`ifdef SSD_LZ_BLANK_EN
    // A digit is blank when it and everything above it is zero
    always_comb begin
        lz_blank = 1'b0;
        case (sel)
            2'd1: lz_blank = (bcd[15:4] == 12'd0);
            2'd2: lz_blank = (bcd[15:8] == 8'd0);
            2'd3: lz_blank = (bcd[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign seg = lz_blank ? SEG_BLANK : seg_decode(digit);

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Randomized self-checking bench for ssd_mux_driver against a decimal
// arithmetic reference of the conversion timing and display multiplexing.
module tb_ssd_mux_driver;

    localparam int RB = 4;

    logic        clk;
    logic        rst;
    logic [12:0] num;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        busy;
    logic [15:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;

    int m_last, m_pend, m_wait, m_val, m_ref;

    ssd_mux_driver #(.REFRESH_BITS(RB), .NUM_W(13)) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .anode (anode),
        .seg   (seg),
        .busy  (busy),
        .bcd   (bcd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: a conversion started from idle publishes its value 14 edges later
    task automatic step();
        int sel, pw;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        if (rst) begin
            m_last = 0; m_wait = 0; m_val = 0; m_ref = 0;
        end else begin
            m_ref = (m_ref + 1) % (1 << RB);
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_val = m_pend;
            end else if (int'(num) != m_last) begin
                m_last = int'(num);
                m_pend = int'(num);
                m_wait = 14;
            end
        end
        #1;
        sel = m_ref / (1 << (RB - 2));
        pw  = (sel == 0) ? 1 : (sel == 1) ? 10 : (sel == 2) ? 100 : 1000;
        exp_an = ~(4'b0001 << sel);
        exp_seg = seg_of(m_val / pw % 10);
`ifdef SSD_LZ_BLANK_EN
        if (sel > 0 && m_val < pw) exp_seg = 7'b1111111;
`endif
        chk("busy",  32'(busy),  32'(m_wait > 0));
        chk("bcd",   32'(bcd),   32'(to_bcd(m_val)));
        chk("anode", 32'(anode), 32'(exp_an));
        chk("seg",   32'(seg),   32'(exp_seg));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_last = 0; m_pend = 0; m_wait = 0; m_val = 0; m_ref = 0;
        rst = 1'b1;
        num = 13'd0;
        run(2);
        rst = 1'b0;
        run(20);

        num = 13'd1234;
        run(40);
        num = 13'd8191;
        run(20);
        num = 13'd9;
        run(20);

        num = 13'd100;
        run(6);
        num = 13'd200;
        run(35);

        num = 13'd5000;
        run(7);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(20);

        num = 13'd0;
        run(20);
        run((1 << RB) + 2);

        for (int k = 0; k < 40; k++) begin
            num = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 9) == 0) begin
                run(int'($urandom_range(1, 13)));
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run(int'($urandom_range(1, 30)));
        end
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
